// File: rtl/ofdm_cp_remove.sv
// ============================================================================
//  Module   : ofdm_cp_remove
//  Purpose  : Streaming cyclic-prefix remover. Discards the NCP prefix
//             samples of every OFDM symbol and forwards the NFFT useful
//             samples, tagged with bin index, symbol-end, frame-end and
//             symbol number. Frames that end early raise a one-cycle trunc.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ofdm_cp_remove #(
  parameter int WIDTH     = 32,
  parameter int NFFT      = 64,
  parameter int NCP       = 16,
  parameter int SYM_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  // input stream
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WIDTH-1:0]        s_data,
  input  logic                    s_first,
  input  logic                    s_last,
  // output stream
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [WIDTH-1:0]        m_data,
  output logic [$clog2(NFFT)-1:0] m_index,
  output logic                    m_last,
  output logic                    m_end,
  output logic [SYM_WIDTH-1:0]    m_symbol,
  output logic                    trunc
);

  // Counter widths: log2 of the terminal count, never narrower than 1 bit.
  localparam int BIN_W = (NFFT > 1) ? $clog2(NFFT) : 1;
  localparam int CP_W  = (NCP  > 1) ? $clog2(NCP)  : 1;

  localparam logic [BIN_W-1:0] c_bin_max = BIN_W'(NFFT - 1);
  localparam logic [CP_W-1:0]  c_cp_max  = CP_W'(NCP - 1);
  localparam logic [CP_W-1:0]  c_cp_one  = CP_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CP   = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CP_W-1:0]        r_cp_cnt;
  logic [CP_W-1:0]        w_cp_cnt_nxt;
  logic [BIN_W-1:0]       r_bin_cnt;
  logic [BIN_W-1:0]       w_bin_cnt_nxt;
  logic [SYM_WIDTH-1:0]   r_sym_cnt;
  logic [SYM_WIDTH-1:0]   w_sym_cnt_nxt;

  logic                   w_s_ready;
  logic                   w_accept;
  logic                   w_load;
  logic                   w_trunc_nxt;

  logic                   r_m_valid;
  logic [WIDTH-1:0]       r_m_data;
  logic [BIN_W-1:0]       r_m_index;
  logic                   r_m_last;
  logic                   r_m_end;
  logic [SYM_WIDTH-1:0]   r_m_symbol;
  logic                   r_trunc;

  // Next-state, counter updates, ready and load/trunc decisions.
  always_comb begin
    w_state_nxt   = r_state;
    w_cp_cnt_nxt  = r_cp_cnt;
    w_bin_cnt_nxt = r_bin_cnt;
    w_sym_cnt_nxt = r_sym_cnt;
    w_load        = 1'b0;
    w_trunc_nxt   = 1'b0;

    // Only DATA can stall the input: prefix and idle beats are always
    // swallowed so the upstream buffer never sees backpressure there.
    w_s_ready = 1'b1;
    if (r_state == ST_DATA) begin
      w_s_ready = !r_m_valid || m_ready;
    end
    w_accept = s_valid && w_s_ready;

    case (r_state)
      ST_IDLE: begin
        if (w_accept && s_first) begin
          w_sym_cnt_nxt = '0;
          w_bin_cnt_nxt = '0;
          w_cp_cnt_nxt  = '0;
          // A one-beat frame (first and last together) is dropped whole.
          if (!s_last) begin
            if (NCP == 1) begin
              w_state_nxt = ST_DATA;
            end else begin
              // This beat is prefix sample 0; the next one is sample 1.
              w_state_nxt  = ST_CP;
              w_cp_cnt_nxt = c_cp_one;
            end
          end
        end
      end

      ST_CP: begin
        if (w_accept) begin
          if (s_last) begin
            w_trunc_nxt  = 1'b1;
            w_state_nxt  = ST_IDLE;
            w_cp_cnt_nxt = '0;
          end else if (r_cp_cnt == c_cp_max) begin
            w_state_nxt   = ST_DATA;
            w_cp_cnt_nxt  = '0;
            w_bin_cnt_nxt = '0;
          end else begin
            w_cp_cnt_nxt = r_cp_cnt + c_cp_one;
          end
        end
      end

      ST_DATA: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (s_last) begin
            w_trunc_nxt   = (r_bin_cnt != c_bin_max);
            w_state_nxt   = ST_IDLE;
            w_bin_cnt_nxt = '0;
          end else if (r_bin_cnt == c_bin_max) begin
            w_sym_cnt_nxt = r_sym_cnt + SYM_WIDTH'(1);
            w_state_nxt   = ST_CP;
            w_cp_cnt_nxt  = '0;
            w_bin_cnt_nxt = '0;
          end else begin
            w_bin_cnt_nxt = r_bin_cnt + BIN_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cp_cnt  <= '0;
      r_bin_cnt <= '0;
      r_sym_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cp_cnt  <= w_cp_cnt_nxt;
      r_bin_cnt <= w_bin_cnt_nxt;
      r_sym_cnt <= w_sym_cnt_nxt;
    end
  end

  // Single output register: load on accepted DATA beat, drain on m_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_index  <= '0;
      r_m_last   <= 1'b0;
      r_m_end    <= 1'b0;
      r_m_symbol <= '0;
    end else if (w_load) begin
      r_m_valid  <= 1'b1;
      r_m_data   <= s_data;
      r_m_index  <= r_bin_cnt;
      r_m_symbol <= r_sym_cnt;
      r_m_last   <= (r_bin_cnt == c_bin_max) || s_last;
      r_m_end    <= s_last;
    end else if (m_ready) begin
      r_m_valid  <= 1'b0;
    end
  end

  // One-cycle truncation pulse, the cycle after the offending beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_trunc <= 1'b0;
    end else begin
      r_trunc <= w_trunc_nxt;
    end
  end

  assign s_ready  = w_s_ready;
  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign m_index  = r_m_index;
  assign m_last   = r_m_last;
  assign m_end    = r_m_end;
  assign m_symbol = r_m_symbol;
  assign trunc    = r_trunc;

endmodule

`default_nettype wire

// File: tb/tb_ofdm_cp_remove.sv
// ============================================================================
//  Module   : tb_ofdm_cp_remove
//  Purpose  : Scoreboard bench for ofdm_cp_remove. Frames are described by
//             length and data; the expected output stream is derived from
//             frame-relative beat arithmetic and compared by a monitor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ofdm_cp_remove;

  localparam int WIDTH  = 32;
  localparam int NFFT   = 64;
  localparam int NCP    = 16;
  localparam int SYMW   = 8;
  localparam int SYMLEN = NFFT + NCP;

  logic              clk;
  logic              reset;
  logic              s_valid;
  logic              s_ready;
  logic [WIDTH-1:0]  s_data;
  logic              s_first;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [WIDTH-1:0]  m_data;
  logic [5:0]        m_index;
  logic              m_last;
  logic              m_end;
  logic [SYMW-1:0]   m_symbol;
  logic              trunc;

  ofdm_cp_remove #(
    .WIDTH    (WIDTH),
    .NFFT     (NFFT),
    .NCP      (NCP),
    .SYM_WIDTH(SYMW)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_first (s_first),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_index (m_index),
    .m_last  (m_last),
    .m_end   (m_end),
    .m_symbol(m_symbol),
    .trunc   (trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [5:0]  idx;
    logic        last;
    logic        fend;
    logic [7:0]  sym;
  } exp_t;

  exp_t        exp_q[$];
  int          total      = 0;
  int          bad        = 0;
  int          trunc_seen = 0;
  int          trunc_exp  = 0;
  int          out_cnt    = 0;
  int          rdy_mode   = 1;   // 0 random, 1 held high, 2 held low
  bit          gaps       = 0;
  logic [31:0] fd [0:511];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Output ready generator; changes only on the falling edge.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rdy_mode == 0) m_ready = 1'($urandom_range(0, 1));
      else               m_ready = (rdy_mode == 1);
    end
  end

  // Monitor: pops the scoreboard on each output handshake, checks that a
  // stalled output holds still, and counts trunc pulses.
  initial begin
    exp_t e;
    exp_t g;
    exp_t held;
    bit   stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        stall = 1'b0;
        continue;
      end
      if (trunc) trunc_seen++;
      g = {m_data, m_index, m_last, m_end, m_symbol};
      if (stall) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_fields", 64'(g), 64'(held));
      end
      if (m_valid && m_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output got=%0h want=none", g);
        end else begin
          e = exp_q.pop_front();
          chk("output", 64'(g), 64'(e));
        end
      end
      stall = m_valid && !m_ready;
      held  = g;
    end
  end

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [31:0] d, input bit f, input bit l, input bit chk_rdy);
    int n;
    bit acc;
    if (gaps) begin
      int ng;
      ng = $urandom_range(0, 2);
      repeat (ng) begin
        @(negedge clk);
        s_valid = 1'b0;
        @(posedge clk);
      end
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_first = f;
    s_last  = l;
    n = 0;
    #2;
    if (chk_rdy) chk("prefix_ready", 64'(s_ready), 64'd1);
    forever begin
      acc = s_ready;
      @(posedge clk);
      if (acc) break;
      n++;
      if (n > 1000) begin
        total++;
        bad++;
        $display("FAIL accept_timeout got=stalled want=accepted");
        break;
      end
      @(negedge clk);
      #2;
    end
  endtask

  // Reference model: a frame of L beats is a run of (NCP+NFFT)-beat symbols;
  // the useful part of each is forwarded, the last forwarded beat closes the
  // frame, and any end other than the final sample of a symbol truncates.
  task automatic model_frame(input int L);
    exp_t e;
    int   pos;
    if (L < 2) return;
    for (int k = 0; k < L; k++) begin
      pos = k % SYMLEN;
      if (pos >= NCP) begin
        e.d    = fd[k];
        e.idx  = 6'(pos - NCP);
        e.last = (pos == SYMLEN - 1) || (k == L - 1);
        e.fend = (k == L - 1);
        e.sym  = 8'(k / SYMLEN);
        exp_q.push_back(e);
      end
    end
    if (((L - 1) % SYMLEN) != SYMLEN - 1) trunc_exp++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic run_frame(input int junk, input int L, input bit seq, input int base);
    for (int k = 0; k < L; k++) fd[k] = seq ? 32'(base + junk + k) : $urandom;
    model_frame(L);
    for (int j = 0; j < junk; j++)
      send(seq ? 32'(base + j) : $urandom, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    for (int k = 0; k < L; k++)
      send(fd[k], k == 0, k == L - 1, (k % SYMLEN) < NCP);
    @(negedge clk);
    s_valid = 1'b0;
    s_first = 1'b0;
    s_last  = 1'b0;
    drain();
    chk("trunc_count", 64'(trunc_seen), 64'(trunc_exp));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #800000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  int special_len [0:3];

  initial begin
    exp_t e;
    s_valid = 1'b0;
    s_data  = '0;
    s_first = 1'b0;
    s_last  = 1'b0;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready",  64'(s_ready),  64'd1);
    chk("rst_m_valid",  64'(m_valid),  64'd0);
    chk("rst_m_data",   64'(m_data),   64'd0);
    chk("rst_m_index",  64'(m_index),  64'd0);
    chk("rst_m_last",   64'(m_last),   64'd0);
    chk("rst_m_end",    64'(m_end),    64'd0);
    chk("rst_m_symbol", 64'(m_symbol), 64'd0);
    chk("rst_trunc",    64'(trunc),    64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Full 3-symbol frame, data = beat number, always ready.
    rdy_mode = 1;
    gaps     = 0;
    out_cnt  = 0;
    run_frame(0, 3 * SYMLEN, 1'b1, 0);
    chk("frame_out_count", 64'(out_cnt), 64'd192);

    // Same frame with random output backpressure.
    rdy_mode = 0;
    run_frame(0, 3 * SYMLEN, 1'b1, 0);

    // Ten stray beats before the frame are discarded.
    run_frame(10, 3 * SYMLEN, 1'b1, 0);

    // Early end inside symbol 0 data, then a fresh frame restarts at symbol 0.
    run_frame(0, 51, 1'b1, 1000);
    run_frame(0, 2 * SYMLEN, 1'b1, 2000);

    // Early end inside the second prefix.
    run_frame(0, 86, 1'b1, 3000);

    // Randomised frames with input gaps, including edge lengths.
    gaps = 1;
    special_len[0] = 1;
    special_len[1] = SYMLEN;
    special_len[2] = NCP + 1;
    special_len[3] = NCP;
    for (int i = 0; i < 12; i++) begin
      int len;
      len = (i < 4) ? special_len[i] : int'($urandom_range(2, 300));
      run_frame(int'($urandom_range(0, 4)), len, 1'b0, 0);
    end

    // Reset while a loaded output is stalled at bin 20.
    gaps     = 0;
    rdy_mode = 1;
    for (int k = 0; k <= NCP + 20; k++) fd[k] = 32'(5000 + k);
    for (int k = NCP; k < NCP + 20; k++) begin
      e.d    = fd[k];
      e.idx  = 6'(k - NCP);
      e.last = 1'b0;
      e.fend = 1'b0;
      e.sym  = 8'd0;
      exp_q.push_back(e);
    end
    for (int k = 0; k <= NCP + 20; k++) send(fd[k], k == 0, 1'b0, k < NCP);
    rdy_mode = 2;
    @(negedge clk);
    s_valid = 1'b0;
    #2;
    chk("pre_reset_valid", 64'(m_valid), 64'd1);
    chk("pre_reset_index", 64'(m_index), 64'd20);
    chk("pre_reset_queue", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_valid", 64'(m_valid), 64'd0);
    chk("post_reset_ready", 64'(s_ready), 64'd1);
    @(negedge clk);
    reset    = 1'b0;
    rdy_mode = 0;
    gaps     = 1;
    run_frame(6, SYMLEN + 30, 1'b1, 7000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
